pipelined_skip_adder: RTL and testbench
=======================================

// Module: pipelined_skip_adder
// PURPOSE
//  Parametrised, pipelined carry-skip adder/subtractor. Next generation of the 32-bit carry-skip adder.
//  Generalised in width, skip-block size and pipeline depth. Adds subtract mode, a valid/ready
//  handshake and registered outputs. Sits between operand-producing logic and the ALU result bus.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; WIDTH % (BLK*STAGES) == 0
//  BLK     4   ripple-block size for carry-skip (bits per skip block)
//  STAGES  2   pipeline register stages (>=1); each stage computes WIDTH/STAGES bits
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: s=a+b+ci; 1: s=a-b (b inverted, carry-in forced 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  s          out  WIDTH  sum/difference
//  co         out  1      carry-out (sub=1: 1 = no borrow, a>=b unsigned)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every stage valid cleared; s, co, out_valid = 0; in_ready = 1 after release.
//  - Skip block: P = &(a_blk ^ b_eff_blk); cout = P ? cin_blk : ripple_cout. Blocks are chained in a stage.
//  - Stage k adds bits [k*W/STAGES +: W/STAGES] using the carry registered by stage k-1.
//    Upper operand slices travel forward in skew registers. Lower sum slices travel forward in
//    de-skew registers. s is presented aligned.
//  - Latency: exactly STAGES cycles from accept (in_valid&&in_ready) to out_valid, with no stall.
//    Throughput is 1 result/cycle.
//  - Handshake: stage k loads when !v[k] || (stage k+1 loads). The last stage "loads" when
//    !out_valid || out_ready. in_ready = stage-0 load condition (combinational from out_ready).
//  - Stall: out_valid=1 && out_ready=0 holds s, co, out_valid stable. Upstream stages fill bubbles,
//    then in_ready drops. No result is lost or duplicated.
//  - Simultaneous accept at input and drain at output on a full pipe: both occur; occupancy unchanged.
//  - Width rules: b_eff = sub ? ~b : b; cin0 = sub ? 1 : ci. Arithmetic is modulo 2^WIDTH.
//    co is the carry out of bit WIDTH-1.
//  - a, b, ci and sub are sampled only on accept; values when in_valid=0 are don't-care.
//  - Reset mid-operation: all in-flight results are discarded; no out_valid pulse after release.
// CONFIGURATION
//  OVF_DETECT_EN defined: extra port ovf (out, 1). ovf = signed two's-complement overflow
//    (carry into MSB ^ carry out of MSB). It is pipelined and aligned with s and held under stall.
//    Reset value is 0.
//  OVF_DETECT_EN undefined: no ovf port and no overflow logic; all other behaviour is identical.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 results in flight -> out_valid=0, s=0, co=0 immediately;
//    nothing emerges after release.
//  2 Add: a=32'hFFFF_FFFF, b=1, ci=0, sub=0 -> after STAGES cycles s=0, co=1 (full skip chain).
//  3 Sub: a=5, b=7, sub=1 -> s=32'hFFFF_FFFE, co=0. Then a=7, b=5 -> s=2, co=1.
//  4 Backpressure: stream 10 random ops with out_ready toggling 1,0,0,1... -> results match the
//    reference model in order, none lost or duplicated; in_ready=0 only when all stages are full
//    and out_ready=0.
//  5 Throughput: in_valid=1 and out_ready=1 for 100 cycles -> 100 results, first one at cycle STAGES.
//  6 OVF_DETECT_EN: a=32'h7FFF_FFFF, b=1, sub=0 -> ovf=1. a=32'h8000_0000, b=1, sub=1 -> ovf=1.
//    a=3, b=4 -> ovf=0. Rerun 2-5 with WIDTH=64, BLK=8, STAGES=4.

Source files
------------

// File: rtl/pipelined_skip_adder.sv
// -----------------------------------------------------------------------------
// pipelined_skip_adder
//   Parametrised pipelined carry-skip adder/subtractor with valid/ready
//   handshake on both sides and registered outputs.
//
//   Each of the STAGES pipeline stages adds WIDTH/STAGES bits using a chain of
//   BLK-bit carry-skip blocks.
//   - Upper operand slices ride forward in skew registers.
//   - Finished lower sum slices ride forward in de-skew registers.
//   The result therefore leaves the last stage aligned.
//
// Parameters
//   WIDTH   operand/sum width; WIDTH % (BLK*STAGES) must be 0
//   BLK     bits per carry-skip block
//   STAGES  pipeline register stages (>= 1)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is combinational
//   a, b, ci, sub       operands; sub=1 computes a-b (ci ignored)
//   out_valid/out_ready result handshake
//   s, co               registered sum/difference and carry-out
//                       (for sub, co=1 means no borrow)
//   ovf                 signed overflow, present only with OVF_DETECT_EN
//
// Build option
//   OVF_DETECT_EN       adds the ovf output and its logic
// -----------------------------------------------------------------------------
module pipelined_skip_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLK    = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = WIDTH / STAGES;  // bits per stage
  localparam int unsigned NB = SW / BLK;        // skip blocks per stage

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin0;
  logic [STAGES-1:0] w_v;    // per-stage valid, last bit is out_valid
  logic [STAGES-1:0] w_ld;   // per-stage load enable

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_s;
  logic              r_co;
`ifdef OVF_DETECT_EN
  logic              r_ovf;
`endif

  // Subtract is a + ~b + 1.
  assign w_b_eff = sub ? ~b : b;
  assign w_cin0  = sub | ci;

  // A stage may load when it is empty or its successor loads this cycle.
  always_comb begin : p_ld
    logic acc;
    w_ld = '0;
    acc  = !w_v[STAGES-1] || out_ready;
    w_ld[STAGES-1] = acc;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      acc     = !w_v[k] || acc;
      w_ld[k] = acc;
    end
  end

  assign in_ready = w_ld[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [SW-1:0] w_a_sl;
    logic [SW-1:0] w_b_sl;
    logic [SW-1:0] w_sum;
    logic          w_cin;
    logic          w_cout;
    logic          w_vin;

    // Operand slice and carry for this stage.
    // Stage 0 takes them from the ports; later stages take them from the
    // previous stage's skew registers.
    if (k == 0) begin : g_src
      assign w_a_sl = a[SW-1:0];
      assign w_b_sl = w_b_eff[SW-1:0];
      assign w_cin  = w_cin0;
      assign w_vin  = in_valid;
    end else begin : g_src
      assign w_a_sl = g_stg[k-1].g_reg.r_ah[SW-1:0];
      assign w_b_sl = g_stg[k-1].g_reg.r_bh[SW-1:0];
      assign w_cin  = g_stg[k-1].g_reg.r_c;
      assign w_vin  = w_v[k-1];
    end

    // Carry-skip chain: ripple inside a block.
    // A fully propagating block passes its carry-in straight through.
    always_comb begin : p_skip
      logic c_blk;
      logic c_rip;
      logic p_blk;
      logic x;
      w_sum = '0;
      c_blk = w_cin;
      c_rip = 1'b0;
      p_blk = 1'b0;
      x     = 1'b0;
      for (int j = 0; j < int'(NB); j++) begin
        c_rip = c_blk;
        p_blk = 1'b1;
        for (int i = 0; i < int'(BLK); i++) begin
          x                      = w_a_sl[j*int'(BLK)+i] ^ w_b_sl[j*int'(BLK)+i];
          w_sum[j*int'(BLK)+i]   = x ^ c_rip;
          c_rip                  = (w_a_sl[j*int'(BLK)+i] & w_b_sl[j*int'(BLK)+i]) | (x & c_rip);
          p_blk                  = p_blk & x;
        end
        c_blk = p_blk ? c_blk : c_rip;
      end
      w_cout = c_blk;
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int unsigned LW = (k + 1) * SW;  // finished low sum bits
      localparam int unsigned HW = WIDTH - LW;    // operand bits still to add

      logic          r_v;
      logic          r_c;
      logic [LW-1:0] r_lo;
      logic [HW-1:0] r_ah;
      logic [HW-1:0] r_bh;

      logic [LW-1:0] w_lo_nxt;
      logic [HW-1:0] w_ah_nxt;
      logic [HW-1:0] w_bh_nxt;

      if (k == 0) begin : g_fwd
        assign w_lo_nxt = w_sum;
        assign w_ah_nxt = a[WIDTH-1:SW];
        assign w_bh_nxt = w_b_eff[WIDTH-1:SW];
      end else begin : g_fwd
        assign w_lo_nxt = {w_sum, g_stg[k-1].g_reg.r_lo};
        assign w_ah_nxt = g_stg[k-1].g_reg.r_ah[WIDTH-k*SW-1:SW];
        assign w_bh_nxt = g_stg[k-1].g_reg.r_bh[WIDTH-k*SW-1:SW];
      end

      // Intermediate stage register; data only moves with valid payloads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v  <= 1'b0;
          r_c  <= 1'b0;
          r_lo <= '0;
          r_ah <= '0;
          r_bh <= '0;
        end else if (w_ld[k]) begin
          r_v <= w_vin;
          if (w_vin) begin
            r_c  <= w_cout;
            r_lo <= w_lo_nxt;
            r_ah <= w_ah_nxt;
            r_bh <= w_bh_nxt;
          end
        end
      end

      assign w_v[k] = r_v;
    end else begin : g_out
      logic [WIDTH-1:0] w_s_nxt;

      if (k == 0) begin : g_fwd
        assign w_s_nxt = w_sum;
      end else begin : g_fwd
        assign w_s_nxt = {w_sum, g_stg[k-1].g_reg.r_lo};
      end

`ifdef OVF_DETECT_EN
      logic w_ovf_nxt;
      // Carry into the MSB is recovered as a^b^sum at the MSB, so the chain
      // needs no extra tap.
      assign w_ovf_nxt = w_a_sl[SW-1] ^ w_b_sl[SW-1] ^ w_sum[SW-1] ^ w_cout;
`endif

      // Output register; holds while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
          r_s         <= '0;
          r_co        <= 1'b0;
`ifdef OVF_DETECT_EN
          r_ovf       <= 1'b0;
`endif
        end else if (w_ld[k]) begin
          r_out_valid <= w_vin;
          if (w_vin) begin
            r_s  <= w_s_nxt;
            r_co <= w_cout;
`ifdef OVF_DETECT_EN
            r_ovf <= w_ovf_nxt;
`endif
          end
        end
      end

      assign w_v[k] = r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign co        = r_co;
`ifdef OVF_DETECT_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_skip_adder.sv
// Testbench for pipelined_skip_adder: scoreboard of reference results plus
// directed scenario tasks.
module tb_pipelined_skip_adder;

  localparam int unsigned W   = 32;
  localparam int unsigned BLK = 4;
  localparam int unsigned STG = 2;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         ci        = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         co;
`ifdef OVF_DETECT_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
`ifdef OVF_DETECT_EN
    logic         ovf;
`endif
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_out = 0;

  pipelined_skip_adder #(.WIDTH(W), .BLK(BLK), .STAGES(STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co)
`ifdef OVF_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain (W+1)-bit arithmetic; overflow from operand and
  // result sign bits.
  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fci, input logic fsub);
    logic [W-1:0] be;
    logic [W:0]   t;
    exp_t         r;
    be   = fsub ? ~fb : fb;
    t    = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, (fsub ? 1'b1 : fci)};
    r.s  = t[W-1:0];
    r.co = t[W];
`ifdef OVF_DETECT_EN
    r.ovf = (fa[W-1] == be[W-1]) && (t[W-1] != fa[W-1]);
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return W'(r);
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ici, input logic isub, input logic ordy);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    ci        = ici;
    sub       = isub;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are sampled on the falling edge, where every
  // signal is stable for the coming rising edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        n_acc = n_out;
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          n_chk++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: output s=%h co=%b with no pending result", s, co);
          end else begin
            e = sb.pop_front();
            if ({s, co} !== {e.s, e.co}) begin
              n_fail++;
              $display("FAIL sb_result: got s=%h co=%b, required s=%h co=%b", s, co, e.s, e.co);
            end
`ifdef OVF_DETECT_EN
            n_chk++;
            if (ovf !== e.ovf) begin
              n_fail++;
              $display("FAIL sb_ovf: got %b, required %b (s=%h)", ovf, e.ovf, s);
            end
`endif
          end
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(a, b, ci, sub));
          n_acc++;
        end
      end
    end
  endtask

  task automatic drain();
    int c = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && c < 50) begin
      next_cycle();
      c++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if ({out_valid, s, co} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got out_valid=%b s=%h co=%b, required all 0", out_valid, s, co);
    end
`ifdef OVF_DETECT_EN
    n_chk++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
    #19 rst_n = 1'b1;
    next_cycle();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add_carry();
    int           lat;
    logic [W-1:0] ones;
    ones = '1;
    drive(1'b1, ones, W'(1), 1'b0, 1'b0, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      next_cycle();
      lat++;
    end
    n_chk++;
    if (lat != int'(STG)) begin
      n_fail++;
      $display("FAIL add_latency: got %0d cycles, required %0d", lat, STG);
    end
    n_chk++;
    if (s !== '0) begin
      n_fail++;
      $display("FAIL add_sum: got %h, required 0", s);
    end
    n_chk++;
    if (co !== 1'b1) begin
      n_fail++;
      $display("FAIL add_co: got %b, required 1", co);
    end
    drain();
  endtask

  task automatic test_sub();
    int got = 0;
    // ci=1 on the first op must be ignored in subtract mode.
    drive(1'b1, W'(5), W'(7), 1'b1, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, W'(7), W'(5), 1'b0, 1'b1, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (out_valid) begin
        n_chk++;
        if (got == 0 && {s, co} !== {~W'(1), 1'b0}) begin
          n_fail++;
          $display("FAIL sub_5_7: got s=%h co=%b, required s=%h co=0", s, co, ~W'(1));
        end
        if (got == 1 && {s, co} !== {W'(2), 1'b1}) begin
          n_fail++;
          $display("FAIL sub_7_5: got s=%h co=%b, required s=2 co=1", s, co);
        end
        got++;
      end
      next_cycle();
    end
    n_chk++;
    if (got != 2) begin
      n_fail++;
      $display("FAIL sub_count: got %0d results, required 2", got);
    end
    drain();
  endtask

`ifdef OVF_DETECT_EN
  task automatic test_ovf();
    logic [W-1:0] maxp;
    logic [W-1:0] minn;
    logic [2:0]   want;
    int           got = 0;
    maxp = '1;
    maxp[W-1] = 1'b0;
    minn = '0;
    minn[W-1] = 1'b1;
    want = 3'b110;
    drive(1'b1, maxp, W'(1), 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, minn, W'(1), 1'b0, 1'b1, 1'b1);
    next_cycle();
    drive(1'b1, W'(3), W'(4), 1'b0, 1'b0, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (out_valid) begin
        n_chk++;
        if (ovf !== want[2-got]) begin
          n_fail++;
          $display("FAIL ovf_%0d: got %b, required %b (s=%h)", got, ovf, want[2-got], s);
        end
        got++;
      end
      next_cycle();
    end
    n_chk++;
    if (got != 3) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d results, required 3", got);
    end
    drain();
  endtask
`endif

  task automatic test_backpressure();
    int   sent = 0;
    int   out0;
    int   occ;
    logic ordy;
    logic exp_rdy;
    out0 = n_out;
    for (int c = 0; c < 200 && (sent < 10 || (n_out - out0) < 10); c++) begin
      ordy = (c % 3 == 0);
      drive(sent < 10, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy);
      #1;
      occ     = n_acc - n_out;
      exp_rdy = !(occ == int'(STG) && !ordy);
      n_chk++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_in_ready: cycle %0d occupancy %0d got %b, required %b", c, occ, in_ready, exp_rdy);
      end
      if (in_valid && in_ready) sent++;
      next_cycle();
    end
    in_valid = 1'b0;
    n_chk++;
    if ((n_out - out0) != 10) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 10", n_out - out0);
    end
    drain();
  endtask

  task automatic test_throughput();
    int first = -1;
    int out0;
    out0 = n_out;
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL tp_in_ready: cycle %0d got %b, required 1", c, in_ready);
      end
      if (out_valid && first < 0) first = c;
      next_cycle();
    end
    drain();
    n_chk++;
    if (first != int'(STG)) begin
      n_fail++;
      $display("FAIL tp_first: first result at cycle %0d, required %0d", first, STG);
    end
    n_chk++;
    if ((n_out - out0) != 100) begin
      n_fail++;
      $display("FAIL tp_count: got %0d results, required 100", n_out - out0);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, W'(32'h12), W'(32'h34), 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, W'(32'h56), W'(32'h78), 1'b0, 1'b0, 1'b0);
    next_cycle();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, s, co} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_clear: got out_valid=%b s=%h co=%b, required all 0", out_valid, s, co);
    end
    next_cycle();
    next_cycle();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_ghost: cycle %0d got out_valid=%b, required 0", c, out_valid);
      end
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_ready: got %b, required 1", in_ready);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_add_carry();
    test_sub();
`ifdef OVF_DETECT_EN
    test_ovf();
`endif
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at %0t, required finish before 100000", $time);
    $fatal(1);
  end

endmodule
